rv_dmem_arb: RTL and testbench
==============================

Name: rv_dmem_arb

Overview:
- Arbitrates the single D_MEM port between two requesters:
  - the core Memory Access stage (Q103H), and
  - an external requester (debug/DMA).
- Sequences each access: writes complete on acceptance; reads hold the port until the response returns.
- Produces the core stall signal that gates the Q104H pipeline registers, and steers read data back to the owning requester.
- Sits between rv_ma and the D_MEM interface.

Parameters:
- STARVE_MAX, 4, number of consecutive core grants allowed while an ext request waits; the next grant is then forced to ext (range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- core_req  in  t_core2mem_req  core request (address, wr_data, wr_en, rd_en, byte_en[3:0])
- core_ready  out  1  core request complete / no stall; drives ready_Q104H
- core_rd_valid  out  1  read data valid for core
- core_rd_data  out  32  read data for core
- ext_req_valid  in  1  ext request valid
- ext_req  in  t_core2mem_req  ext request
- ext_req_ready  out  1  ext request complete
- ext_rd_valid  out  1  read data valid for ext
- ext_rd_data  out  32  read data for ext
- mem_req_valid  out  1  request to D_MEM valid
- mem_req  out  t_core2mem_req  request to D_MEM
- mem_req_ready  in  1  D_MEM accepts request this cycle
- mem_rsp_valid  in  1  D_MEM read data valid
- mem_rsp_data  in  32  D_MEM read data

Behaviour:
- Core request valid: core_req.rd_en | core_req.wr_en.
- If both wr_en and rd_en are set on either requester, the access is issued as a write.
- Requesters hold their request stable until their ready pulses.
- FSM states: IDLE, RD_WAIT. Registers: owner (CORE/EXT), starve_cnt (4 bits).
- IDLE arbitration:
  - Ext wins if ext_req_valid and (core not valid or starve_cnt == STARVE_MAX).
  - Otherwise core wins if valid.
- IDLE drive: mem_req_valid = 1 and mem_req = winner's request (combinational, same cycle).
- On mem_req_ready in IDLE:
  - Write: the winner's ready pulses 1 in the same cycle; state stays IDLE.
  - Read: owner <= winner; state -> RD_WAIT; the winner's ready stays 0.
- RD_WAIT:
  - mem_req_valid = 0.
  - On mem_rsp_valid: owner's rd_valid = 1, owner's rd_data = mem_rsp_data, owner's ready = 1 (same cycle); state -> IDLE.
  - The next request can issue the following cycle.
- Read latency: one cycle plus memory latency, minimum. Write latency: zero extra cycles when mem_req_ready is 1.
- core_ready:
  - 1 when the core has no valid request.
  - Otherwise 1 only in its completion cycle; 0 while waiting or while ext owns the port.
- ext_req_ready: 1 only in ext completion cycles.
- rd_data for the non-owner: 0.
- starve_cnt updates on each completed grant:
  - Core grant with ext_req_valid = 1: +1, saturating at STARVE_MAX.
  - Ext grant: reset to 0.
  - Cycle with ext_req_valid = 0: reset to 0.
- mem_rsp_valid in IDLE is spurious and is ignored; no output changes.
- Reset (rst = 0), asynchronous:
  - State = IDLE, owner = CORE, starve_cnt = 0.
  - All valid/ready outputs forced 0; data outputs 0.
  - A read in flight is dropped; its late response is ignored.
  - After reset deasserts, arbitration resumes on the next rising edge.

Test Plan:
- Core write addr 0x100, data 0xDEADBEEF, byte_en 0xF, mem_req_ready = 1 -> mem_req_valid = 1 with the same fields in that cycle; core_ready = 1 in that cycle.
- Core read addr 0x40, memory responds 3 cycles later with 0x12345678 -> core_ready = 0 for 3 cycles; then core_ready = 1, core_rd_valid = 1, core_rd_data = 0x12345678; ext_rd_valid = 0.
- Core and ext both issue writes every cycle, STARVE_MAX = 4 -> grant pattern is core×4, ext×1, repeating; ext_req_ready pulses every 5th cycle.
- Ext read outstanding while core issues a write -> core_ready = 0 until the ext response cycle; the core write issues the next cycle.
- Assert rst = 0 mid RD_WAIT, release, then mem_rsp_valid = 1 -> no rd_valid pulse on either requester; state = IDLE; starve_cnt = 0.
- mem_req_ready held 0 for 5 cycles on a core write -> mem_req held stable, core_ready = 0 throughout; completes in the cycle ready rises.

Source files
------------

// File: rtl/rv_dmem_arb_if.sv
// rtl/rv_dmem_arb_if.sv - request type and bus interface for the D_MEM port arbiter
package rv_dmem_pkg;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wr_data;
        logic        wr_en;
        logic        rd_en;
        logic [3:0]  byte_en;
    } t_core2mem_req;
endpackage

interface rv_dmem_arb_if;
    import rv_dmem_pkg::*;

    t_core2mem_req core_req;
    logic          core_ready;
    logic          core_rd_valid;
    logic [31:0]   core_rd_data;
    logic          ext_req_valid;
    t_core2mem_req ext_req;
    logic          ext_req_ready;
    logic          ext_rd_valid;
    logic [31:0]   ext_rd_data;
    logic          mem_req_valid;
    t_core2mem_req mem_req;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;

    // slave: the arbiter's view; master: the surrounding requesters and memory
    modport slave (
        input  core_req, ext_req_valid, ext_req, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output core_ready, core_rd_valid, core_rd_data, ext_req_ready, ext_rd_valid,
               ext_rd_data, mem_req_valid, mem_req
    );
    modport master (
        output core_req, ext_req_valid, ext_req, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  core_ready, core_rd_valid, core_rd_data, ext_req_ready, ext_rd_valid,
               ext_rd_data, mem_req_valid, mem_req
    );
endinterface

// File: rtl/rv_dmem_arb.sv
// rtl/rv_dmem_arb.sv - D_MEM port arbiter between core MA stage and an external requester
module rv_dmem_arb
    import rv_dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    rv_dmem_arb_if.slave bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;
    localparam logic       OWN_CORE   = 1'b0;
    localparam logic       OWN_EXT    = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [0:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [3:0]    starve_q, starve_d;

    logic          core_valid, ext_win, core_win;
    t_core2mem_req win_req;
    logic          core_done, ext_done;
    logic          mem_valid;
    t_core2mem_req mem_req;
    logic          core_rvld, ext_rvld;
    logic [31:0]   core_rdat, ext_rdat;
    logic          core_rdy;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        core_valid = bus.core_req.rd_en | bus.core_req.wr_en;
        ext_win    = bus.ext_req_valid && (!core_valid || starve_q == STARVE_LIM);
        core_win   = core_valid && !ext_win;
        win_req    = ext_win ? bus.ext_req : bus.core_req;
        core_done  = 1'b0;
        ext_done   = 1'b0;
        mem_valid  = 1'b0;
        mem_req    = '0;
        core_rvld  = 1'b0;
        ext_rvld   = 1'b0;
        core_rdat  = '0;
        ext_rdat   = '0;
        core_rdy   = 1'b0;

        // outputs stay quiet while reset is held, even though requesters may still be driving
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (ext_win || core_win) begin
                        mem_valid = 1'b1;
                        mem_req   = win_req;
                        if (win_req.wr_en) begin
                            mem_req.rd_en = 1'b0;
                        end
                        if (bus.mem_req_ready) begin
                            if (win_req.wr_en) begin
                                core_done = core_win;
                                ext_done  = ext_win;
                            end else begin
                                state_d = ST_RD_WAIT;
                                owner_d = ext_win ? OWN_EXT : OWN_CORE;
                            end
                            if (ext_win) begin
                                starve_d = '0;
                            end else if (bus.ext_req_valid && starve_q < STARVE_LIM) begin
                                starve_d = starve_q + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.mem_rsp_valid) begin
                        state_d = ST_IDLE;
                        if (owner_q == OWN_EXT) begin
                            ext_rvld = 1'b1;
                            ext_rdat = bus.mem_rsp_data;
                            ext_done = 1'b1;
                        end else begin
                            core_rvld = 1'b1;
                            core_rdat = bus.mem_rsp_data;
                            core_done = 1'b1;
                        end
                    end
                end
            endcase
            if (!bus.ext_req_valid) begin
                starve_d = '0;
            end
            core_rdy = !core_valid || core_done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_CORE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    assign bus.mem_req_valid = mem_valid;
    assign bus.mem_req       = mem_req;
    assign bus.core_ready    = core_rdy;
    assign bus.core_rd_valid = core_rvld;
    assign bus.core_rd_data  = core_rdat;
    assign bus.ext_req_ready = ext_done;
    assign bus.ext_rd_valid  = ext_rvld;
    assign bus.ext_rd_data   = ext_rdat;
endmodule

// File: tb/tb_rv_dmem_arb.sv
// tb/tb_rv_dmem_arb.sv - self-checking bench for rv_dmem_arb
module tb_rv_dmem_arb;
    import rv_dmem_pkg::*;

    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv_dmem_arb_if bus_if();

    rv_dmem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // reference: which requester awaits read data (-1 none, 0 core, 1 ext),
    // and how many core grants in a row ext has been made to sit out
    int   pending = -1;
    int   streak  = 0;
    logic last_core_ready = 1'b0;
    logic last_ext_ready  = 1'b0;
    int   ext_pulses;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkreq(input string name, input t_core2mem_req act, input t_core2mem_req exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        t_core2mem_req r;
        logic core_v, ext_go, core_go;
        logic e_mv, e_cr, e_er, e_crv, e_erv;
        logic [31:0] e_cd, e_ed;
        @(negedge clk);
        core_v = bus_if.core_req.rd_en | bus_if.core_req.wr_en;
        r = '0;
        {e_mv, e_cr, e_er, e_crv, e_erv} = '0;
        e_cd = '0;
        e_ed = '0;
        if (!rst) begin
            pending = -1;
            streak  = 0;
        end else begin
            if (pending < 0) begin
                ext_go  = bus_if.ext_req_valid && (!core_v || streak >= STARVE_MAX);
                core_go = core_v && !ext_go;
                if (ext_go || core_go) begin
                    r = ext_go ? bus_if.ext_req : bus_if.core_req;
                    if (r.wr_en) r.rd_en = 1'b0;
                    e_mv = 1'b1;
                    if (bus_if.mem_req_ready) begin
                        if (r.wr_en) begin
                            e_cr = core_go;
                            e_er = ext_go;
                        end else begin
                            pending = ext_go ? 1 : 0;
                        end
                        if (ext_go) streak = 0;
                        else if (bus_if.ext_req_valid) streak = (streak + 1 > STARVE_MAX) ? STARVE_MAX : streak + 1;
                    end
                end
            end else if (bus_if.mem_rsp_valid) begin
                if (pending == 1) begin
                    e_erv = 1'b1; e_ed = bus_if.mem_rsp_data; e_er = 1'b1;
                end else begin
                    e_crv = 1'b1; e_cd = bus_if.mem_rsp_data; e_cr = 1'b1;
                end
                pending = -1;
            end
            if (!bus_if.ext_req_valid) streak = 0;
            if (!core_v) e_cr = 1'b1;
        end
        chk1("mem_req_valid", bus_if.mem_req_valid, e_mv);
        if (e_mv) chkreq("mem_req", bus_if.mem_req, r);
        chk1("core_ready", bus_if.core_ready, e_cr);
        chk1("ext_req_ready", bus_if.ext_req_ready, e_er);
        chk1("core_rd_valid", bus_if.core_rd_valid, e_crv);
        chk1("ext_rd_valid", bus_if.ext_rd_valid, e_erv);
        if (e_crv || e_erv || !rst) begin
            chk32("core_rd_data", bus_if.core_rd_data, e_cd);
            chk32("ext_rd_data", bus_if.ext_rd_data, e_ed);
        end
        last_core_ready = e_cr;
        last_ext_ready  = e_er;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    function automatic t_core2mem_req mk(input logic rd, input logic wr, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] be);
        t_core2mem_req q;
        q.address = a; q.wr_data = d; q.wr_en = wr; q.rd_en = rd; q.byte_en = be;
        return q;
    endfunction

    function automatic t_core2mem_req rand_req(input int kind);
        return mk(kind[0], kind[1], {20'h0, $urandom_range(0, 4095)}, $urandom, 4'($urandom_range(0, 15)));
    endfunction

    initial begin
        bus_if.core_req      = mk(1'b0, 1'b1, 32'h10, 32'h1, 4'hF);
        bus_if.ext_req_valid = 1'b1;
        bus_if.ext_req       = mk(1'b0, 1'b1, 32'h20, 32'h2, 4'hF);
        bus_if.mem_req_ready = 1'b1;
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_rsp_data  = '0;
        advance();

        // reset holds every output low despite live requests
        sample();
        chk1("rst_mem_valid", bus_if.mem_req_valid, 1'b0);
        chk1("rst_core_ready", bus_if.core_ready, 1'b0);
        advance();
        rst = 1'b1;
        bus_if.core_req = '0;
        bus_if.ext_req_valid = 1'b0;

        // core write completes in the acceptance cycle
        bus_if.core_req = mk(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        sample();
        chk1("wr_mem_valid", bus_if.mem_req_valid, 1'b1);
        chk32("wr_addr", bus_if.mem_req.address, 32'h100);
        chk32("wr_data", bus_if.mem_req.wr_data, 32'hDEADBEEF);
        chk1("wr_core_ready", bus_if.core_ready, 1'b1);
        advance();

        // core read, response three cycles after issue
        bus_if.core_req = mk(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk1("rd_wait_core_ready", bus_if.core_ready, 1'b0);
            advance();
        end
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rsp_data  = 32'h12345678;
        sample();
        chk1("rd_core_ready", bus_if.core_ready, 1'b1);
        chk1("rd_core_valid", bus_if.core_rd_valid, 1'b1);
        chk32("rd_core_data", bus_if.core_rd_data, 32'h12345678);
        chk1("rd_ext_valid", bus_if.ext_rd_valid, 1'b0);
        advance();
        bus_if.mem_rsp_valid = 1'b0;

        // both requesters write every cycle: core x4, ext x1
        bus_if.core_req      = mk(1'b0, 1'b1, 32'h300, 32'hAAAA0000, 4'h3);
        bus_if.ext_req_valid = 1'b1;
        bus_if.ext_req       = mk(1'b0, 1'b1, 32'h400, 32'h5555FFFF, 4'hC);
        ext_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            chk1("starve_ext_ready", bus_if.ext_req_ready, (i % 5) == 4);
            chk1("starve_core_ready", bus_if.core_ready, (i % 5) != 4);
            if (bus_if.ext_req_ready) ext_pulses++;
            advance();
        end
        checks++;
        if (ext_pulses != 4) begin
            errors++;
            $display("FAIL starve_pulse_count: got %0d expected 4", ext_pulses);
        end

        // ext read outstanding blocks a core write until the response cycle
        bus_if.core_req = '0;
        bus_if.ext_req  = mk(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
        sample();
        chk1("extrd_issue", bus_if.mem_req_valid, 1'b1);
        advance();
        bus_if.core_req = mk(1'b0, 1'b1, 32'h500, 32'h0BADF00D, 4'hF);
        sample();
        chk1("extrd_core_blocked", bus_if.core_ready, 1'b0);
        advance();
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rsp_data  = 32'hCAFEF00D;
        sample();
        chk1("extrd_ready", bus_if.ext_req_ready, 1'b1);
        chk32("extrd_data", bus_if.ext_rd_data, 32'hCAFEF00D);
        chk32("extrd_core_data", bus_if.core_rd_data, 32'h0);
        chk1("extrd_core_still", bus_if.core_ready, 1'b0);
        advance();
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.ext_req_valid = 1'b0;
        sample();
        chk32("extrd_core_issue", bus_if.mem_req.address, 32'h500);
        chk1("extrd_core_done", bus_if.core_ready, 1'b1);
        advance();

        // reset in the middle of a read drops the late response
        bus_if.core_req = mk(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        sample();
        advance();
        sample();
        advance();
        rst = 1'b0;
        sample();
        advance();
        rst = 1'b1;
        bus_if.core_req = '0;
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rsp_data  = 32'h77777777;
        sample();
        chk1("rstrd_core_valid", bus_if.core_rd_valid, 1'b0);
        chk1("rstrd_ext_valid", bus_if.ext_rd_valid, 1'b0);
        advance();
        bus_if.mem_rsp_valid = 1'b0;

        // memory stalls a core write for five cycles
        bus_if.core_req = mk(1'b0, 1'b1, 32'h200, 32'h13572468, 4'h5);
        bus_if.mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk32("stall_addr", bus_if.mem_req.address, 32'h200);
            chk1("stall_core_ready", bus_if.core_ready, 1'b0);
            advance();
        end
        bus_if.mem_req_ready = 1'b1;
        sample();
        chk1("stall_done", bus_if.core_ready, 1'b1);
        advance();
        bus_if.core_req = '0;

        // randomized traffic against the reference
        last_core_ready = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            if (last_core_ready) bus_if.core_req = rand_req($urandom_range(0, 3));
            if (!bus_if.ext_req_valid || last_ext_ready) begin
                bus_if.ext_req_valid = ($urandom_range(0, 9) < 6);
                bus_if.ext_req       = rand_req($urandom_range(1, 3));
            end
            bus_if.mem_req_ready = ($urandom_range(0, 3) != 0);
            bus_if.mem_rsp_valid = (pending >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            bus_if.mem_rsp_data  = $urandom;
            sample();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
